// File: rtl/key_expansion_iter_pkg.sv
// Shared AES key-schedule constants, FSM encoding, S-box table and byte helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_expansion_iter_pkg;

    localparam int          NB             = 4;        // state columns, fixed for AES
    localparam logic [7:0]  AES_RCON_INIT  = 8'h01;
    localparam logic [7:0]  AES_XTIME_POLY = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply by x; walks Rcon 01,02,04,...,80,1b,36.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? AES_XTIME_POLY : 8'h00);
    endfunction

    // Cyclic left byte rotation: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expansion_iter_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of word_i.
// Ports: word_i - input word; word_o - byte-wise substituted word.
module key_expansion_iter_sub_word
    import key_expansion_iter_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign word_o[8*k +: 8] = SBOX[word_i[8*k +: 8]];
    end

endmodule

// File: rtl/key_expansion_iter.sv
// Iterative AES-128/192/256 key schedule, one 32-bit round-key word per clock.
// Latency: start captured at edge E0, w[i] registered on outputs after edge E(1+i); o_done one cycle after w[NW-1].
// Backpressure: none; the stream of NW words is unconditional once started, i_start ignored while busy or done.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start/i_key start request and key (w[0] in MSBs);
//        o_busy run in progress; o_word_valid/o_word/o_word_idx word stream; o_done one-cycle completion pulse.
module key_expansion_iter
    import key_expansion_iter_pkg::*;
#(
    parameter int NK = 4
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [32*NK-1:0]  i_key,
    output logic              o_busy,
    output logic              o_word_valid,
    output logic [31:0]       o_word,
    output logic [5:0]        o_word_idx,
    output logic              o_done
);

    localparam int         NR        = NK + 6;
    localparam int         NW        = NB * (NR + 1);
    localparam logic [5:0] LOAD_LAST = 6'(NK - 1);
    localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
    localparam logic [2:0] PH_LAST   = 3'(NK - 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("key_expansion_iter: NK must be 4, 6 or 8");
    end

    state_e      state_q;
    logic [31:0] win_q [NK];     // win_q[0] = w[i-NK] ... win_q[NK-1] = w[i-1]
    logic [7:0]  rcon_q;
    logic [5:0]  cnt_q;          // index of the next word to emit
    logic [2:0]  ph_q;           // cnt_q mod NK, kept as a counter to avoid a divider
    logic        busy_q, vld_q, done_q;
    logic [31:0] word_q;
    logic [5:0]  idx_q;

    logic [31:0] last_w, sub_in, sub_out, temp;
    logic [31:0] word_d;
    logic [5:0]  cnt_d;
    logic [2:0]  ph_d;

    assign last_w = win_q[NK-1];
    // One S-box bank serves both the RotWord+SubWord step and the NK=8 SubWord-only step.
    assign sub_in = (ph_q == 3'd0) ? rot_word(last_w) : last_w;

    key_expansion_iter_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        temp = last_w;
        if (ph_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && ph_q == 3'd4) begin
            temp = sub_out;
        end
    end

    assign word_d = win_q[0] ^ temp;
    assign cnt_d  = cnt_q + 6'd1;
    assign ph_d   = (ph_q == PH_LAST) ? 3'd0 : ph_q + 3'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            rcon_q  <= AES_RCON_INIT;
            cnt_q   <= '0;
            ph_q    <= '0;
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // The cycle showing o_done is already IDLE; a start there is dropped.
                    if (i_start && !done_q) begin
                        for (int k = 0; k < NK; k++) win_q[k] <= i_key[32*(NK-k)-1 -: 32];
                        rcon_q  <= AES_RCON_INIT;
                        cnt_q   <= '0;
                        ph_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Emit the key words by rotating the window once around; it ends where it began.
                    word_q <= win_q[0];
                    idx_q  <= cnt_q;
                    vld_q  <= 1'b1;
                    for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
                    win_q[NK-1] <= win_q[0];
                    cnt_q  <= cnt_d;
                    ph_q   <= ph_d;
                    if (cnt_q == LOAD_LAST) state_q <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    word_q <= word_d;
                    idx_q  <= cnt_q;
                    vld_q  <= 1'b1;
                    for (int k = 0; k < NK-1; k++) win_q[k] <= win_q[k+1];
                    win_q[NK-1] <= word_d;
                    if (ph_q == 3'd0) rcon_q <= xtime(rcon_q);
                    cnt_q  <= cnt_d;
                    ph_q   <= ph_d;
                    if (cnt_q == LAST_IDX) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_word_valid = vld_q;
    assign o_word       = word_q;
    assign o_word_idx   = idx_q;
    assign o_done       = done_q;

endmodule
